modport_ahb_apb_bridge: RTL and testbench
=========================================

// Module: modport_ahb_apb_bridge
// PURPOSE
//  AHB-Lite slave to APB master bridge. It sits between the AHB bus (driven through the AHB_DRV_MP modport)
//  and up to four APB peripherals. Each valid AHB single transfer becomes one APB SETUP+ENABLE access.
//  Wait states are returned to AHB through Hreadyout.
// PARAMETERS
//  ADDR_W   32           AHB/APB address width
//  DATA_W   32           AHB/APB data width
//  NSLV     4            number of APB selects (Pselx width)
//  BASE     32'h8000_0000  start of bridge address window
//  SLV_SPAN 32'h0400_0000  bytes per APB slave region
// PORTS
//  Hclk       in   1       clock, all logic on posedge
//  Hresetn    in   1       reset; synchronous, active-high (1 = reset)
//  Htrans     in   2       00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  Hsize      in   3       transfer size, registered and ignored (full-word APB access)
//  Hreadyin   in   1       previous transfer complete on bus
//  Haddr      in   ADDR_W  AHB address
//  Hwrite     in   1       1 = write
//  Hwdata     in   DATA_W  write data (data phase, one cycle after address)
//  Hrdata     out  DATA_W  read data
//  Hresp      out  2       response, always 2'b00 OKAY
//  Hreadyout  out  1       0 inserts AHB wait state
//  Pselx      out  NSLV    one-hot APB select
//  Penable    out  1       APB enable phase
//  Pwrite     out  1       APB direction
//  Paddr      out  ADDR_W  APB address
//  Pwdata     out  DATA_W  APB write data
//  Prdata     in   DATA_W  APB read data
// BEHAVIOUR
//  - valid = Hreadyin & Htrans[1] & (BASE <= Haddr < BASE+NSLV*SLV_SPAN). BUSY/IDLE/out-of-range/Hreadyin=0 ignored.
//  - Decode: Pselx[i] = 1 for region i = (Haddr-BASE)/SLV_SPAN; 0x8000_0000->0001, 0x8400_0000->0010, 0x8800_0000->0100, 0x8C00_0000->1000.
//  - On valid, Haddr/Hwrite/Hsize are latched into address-phase registers.
//  - FSM states: IDLE, WWAIT, SETUP, ENABLE. All outputs are driven from state and registers.
//  - IDLE: Hreadyout=1. If valid & Hwrite -> WWAIT. If valid & !Hwrite -> SETUP. Otherwise stay.
//  - WWAIT: Hreadyout=0. Capture Hwdata into Pwdata. -> SETUP.
//  - SETUP: Pselx=decoded, Penable=0, Paddr/Pwrite from latch, Hreadyout=0. -> ENABLE.
//  - ENABLE: Pselx held, Penable=1, Hreadyout=1. On a read, Hrdata=Prdata in this cycle.
//    Next state: new valid sampled -> WWAIT or SETUP (same rule as IDLE); else IDLE.
//  - Latency: read = addr cycle + 2 (data in ENABLE); write = addr cycle + 3.
//  - Hrdata=0 outside ENABLE-of-read. Hresp is always OKAY; no error generation.
//  - Pselx=0 and Penable=0 in IDLE/WWAIT. Paddr/Pwrite/Pwdata hold their last values.
//  - Reset (any state, synchronous): state=IDLE, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0,
//    Hrdata=0, Hreadyout=1, Hresp=00. An in-flight access is abandoned, with no Penable pulse.
//  - No APB PREADY/PSLVERR: every APB access completes in exactly one ENABLE cycle.
// STRUCTURE
//  - Package ahb_apb_pkg: HTRANS_* constants, RESP_OKAY, BASE/SLV_SPAN, state enum {IDLE,WWAIT,SETUP,ENABLE}.
//  - Sub-module ahb_slave_if: valid detection, address decode, address-phase pipeline registers.
//  - Top holds the FSM and the APB output registers.
// TESTING
//  - Reset: Hresetn=1 for 2 clk -> Pselx=0, Penable=0, Hreadyout=1, Hresp=00, Hrdata=0.
//  - Single write: Haddr=0x8000_0010, NONSEQ, Hwrite=1, Hwdata=0xDEADBEEF ->
//    SETUP with Pselx=0001, Paddr=0x8000_0010, Pwdata=0xDEADBEEF, Pwrite=1; then Penable=1; Hreadyout low 2 cycles.
//  - Single read: Haddr=0x8800_0004, Prdata=0x1234_5678 ->
//    Pselx=0100, Pwrite=0; Hrdata=0x1234_5678 with Hreadyout=1 in ENABLE.
//  - Ignored transfers: Htrans=IDLE, BUSY, Hreadyin=0, or Haddr=0x7000_0000 ->
//    no Pselx activity, Hreadyout stays 1.
//  - Back-to-back: read 0x8400_0000 then write 0x8C00_0008 issued in ENABLE ->
//    Pselx 0010 then 1000, no IDLE gap.
//  - Reset asserted during SETUP of a write -> next clk IDLE, Pselx=0, Penable never asserted.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared constants, bus encodings and FSM state type for the AHB-Lite to APB bridge.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Bridge address window: NSLV consecutive regions of SLV_SPAN bytes from BASE.
    localparam logic [31:0] BASE     = 32'h8000_0000;
    localparam logic [31:0] SLV_SPAN = 32'h0400_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WWAIT  = 2'b01,
        SETUP  = 2'b10,
        ENABLE = 2'b11
    } state_t;

endpackage

// File: rtl/ahb_slave_if.sv
// AHB-side front end: transfer qualification, window decode and address-phase capture.
// The *_next outputs show what the capture registers hold after the coming edge, so the
// top can load its APB registers on the same edge a read is accepted.
module ahb_slave_if
    import ahb_apb_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              NSLV      = 4,
    parameter int              REG_W     = (NSLV > 1) ? $clog2(NSLV) : 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR = BASE,
    parameter logic [ADDR_W-1:0] SPAN      = SLV_SPAN
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [1:0]        htrans,
    input  logic              hreadyin,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic              accept,
    output logic              valid,
    output logic [ADDR_W-1:0] addr_next,
    output logic              write_next,
    output logic [REG_W-1:0]  region_next
);

    // Total window size, one bit wider so BASE+window cannot wrap.
    localparam logic [ADDR_W:0] WIN_SIZE = (ADDR_W+1)'(NSLV) * {1'b0, SPAN};

    logic [ADDR_W-1:0] offset;
    logic              in_win;
    logic [REG_W-1:0]  region;

    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic              write_q,  write_d;
    logic [REG_W-1:0]  region_q, region_d;
    logic [2:0]        hsize_q,  hsize_d;

    // Size is captured for completeness only; every APB access is a full word.
    logic hsize_unused;
    assign hsize_unused = ^{hsize_q, htrans[0]};

    // Qualify the current address phase and find its slave region.
    always_comb begin
        offset = haddr - BASE_ADDR;
        in_win = (haddr >= BASE_ADDR) && ({1'b0, offset} < WIN_SIZE);
        valid  = hreadyin && htrans[1] && in_win;
        region = REG_W'(offset / SPAN);
    end

    // Address-phase capture only when the FSM actually takes the transfer.
    always_comb begin
        addr_d   = addr_q;
        write_d  = write_q;
        region_d = region_q;
        hsize_d  = hsize_q;
        if (accept) begin
            addr_d   = haddr;
            write_d  = hwrite;
            region_d = region;
            hsize_d  = hsize;
        end
    end

    assign addr_next   = addr_d;
    assign write_next  = write_d;
    assign region_next = region_d;

    // Capture register update.
    always_ff @(posedge clk) begin
        if (srst) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            region_q <= '0;
            hsize_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            write_q  <= write_d;
            region_q <= region_d;
            hsize_q  <= hsize_d;
        end
    end

endmodule

// File: rtl/modport_ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge: one AHB single transfer becomes one APB
// SETUP+ENABLE access, with writes taking an extra cycle to collect Hwdata.
module modport_ahb_apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 4
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic [1:0]        Htrans,
    input  logic [2:0]        Hsize,
    input  logic              Hreadyin,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic              Hwrite,
    input  logic [DATA_W-1:0] Hwdata,
    output logic [DATA_W-1:0] Hrdata,
    output logic [1:0]        Hresp,
    output logic              Hreadyout,
    output logic [NSLV-1:0]   Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    input  logic [DATA_W-1:0] Prdata
);

    localparam int REG_W = (NSLV > 1) ? $clog2(NSLV) : 1;

    // Reset is active-high despite the AHB-style port name.
    logic clk, srst;
    assign clk  = Hclk;
    assign srst = Hresetn;

    state_t state_q, state_d;

    logic              valid, accept;
    logic [ADDR_W-1:0] addr_next;
    logic              write_next;
    logic [REG_W-1:0]  region_next;

    logic [ADDR_W-1:0] paddr_q,  paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [REG_W-1:0]  region_q, region_d;

    // A new transfer can only be taken while the AHB side sees Hreadyout high.
    assign accept = valid && ((state_q == IDLE) || (state_q == ENABLE));

    ahb_slave_if #(
        .ADDR_W (ADDR_W),
        .NSLV   (NSLV),
        .REG_W  (REG_W)
    ) u_slave_if (
        .clk         (clk),
        .srst        (srst),
        .htrans      (Htrans),
        .hreadyin    (Hreadyin),
        .haddr       (Haddr),
        .hwrite      (Hwrite),
        .hsize       (Hsize),
        .accept      (accept),
        .valid       (valid),
        .addr_next   (addr_next),
        .write_next  (write_next),
        .region_next (region_next)
    );

    // Next-state logic and APB register loads.
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        region_d = region_q;
        case (state_q)
            IDLE, ENABLE: begin
                if (valid) state_d = Hwrite ? WWAIT : SETUP;
                else       state_d = IDLE;
            end
            WWAIT: begin
                state_d  = SETUP;
                pwdata_d = Hwdata;
            end
            SETUP:   state_d = ENABLE;
            default: state_d = IDLE;
        endcase
        // APB address/direction/select change only as a SETUP phase begins.
        if (state_d == SETUP) begin
            paddr_d  = addr_next;
            pwrite_d = write_next;
            region_d = region_next;
        end
    end

    // State and APB register update.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            region_q <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            region_q <= region_d;
        end
    end

    // Bus outputs decoded from the registered state.
    always_comb begin
        Pselx     = '0;
        Penable   = 1'b0;
        Hreadyout = 1'b1;
        Hrdata    = '0;
        case (state_q)
            WWAIT: Hreadyout = 1'b0;
            SETUP: begin
                Pselx     = {{(NSLV-1){1'b0}}, 1'b1} << region_q;
                Hreadyout = 1'b0;
            end
            ENABLE: begin
                Pselx   = {{(NSLV-1){1'b0}}, 1'b1} << region_q;
                Penable = 1'b1;
                if (!pwrite_q) Hrdata = Prdata;
            end
            default: ;
        endcase
    end

    assign Hresp  = RESP_OKAY;
    assign Paddr  = paddr_q;
    assign Pwrite = pwrite_q;
    assign Pwdata = pwdata_q;

endmodule

// File: tb/tb_modport_ahb_apb_bridge.sv
// Directed bench for the AHB-Lite to APB bridge with a cycle-indexed expectation model.
module tb_modport_ahb_apb_bridge;

    localparam int MAXC = 128;
    localparam logic [31:0] WBASE = 32'h8000_0000;
    localparam logic [31:0] WSPAN = 32'h0400_0000;

    logic        Hclk = 1'b0;
    logic        Hresetn = 1'b1;
    logic [1:0]  Htrans = 2'b00;
    logic [2:0]  Hsize = 3'b010;
    logic        Hreadyin = 1'b1;
    logic [31:0] Haddr = '0;
    logic        Hwrite = 1'b0;
    logic [31:0] Hwdata = '0;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;
    logic        Hreadyout;
    logic [3:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata = '0;

    modport_ahb_apb_bridge dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Htrans    (Htrans),
        .Hsize     (Hsize),
        .Hreadyin  (Hreadyin),
        .Haddr     (Haddr),
        .Hwrite    (Hwrite),
        .Hwdata    (Hwdata),
        .Hrdata    (Hrdata),
        .Hresp     (Hresp),
        .Hreadyout (Hreadyout),
        .Pselx     (Pselx),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata)
    );

    always #5 Hclk = ~Hclk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = -1;
    int free_cyc = 0;

    // Expected outputs per cycle, filled in as transfers are accepted.
    logic [3:0]  e_sel    [MAXC];
    logic        e_en     [MAXC];
    logic        e_rdy    [MAXC];
    logic        e_rd     [MAXC];
    logic        e_wd     [MAXC];
    logic [31:0] e_paddr  [MAXC];
    logic        e_pwrite [MAXC];
    logic [31:0] e_pwdata [MAXC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_from(input int first);
        for (int k = first; k < MAXC; k++) begin
            e_sel[k] = 4'b0000; e_en[k] = 1'b0; e_rdy[k] = 1'b1; e_rd[k] = 1'b0;
            e_wd[k] = 1'b0; e_paddr[k] = '0; e_pwrite[k] = 1'b0; e_pwdata[k] = '0;
        end
    endtask

    // One bus cycle: apply inputs, update the model, wait to the sampling edge.
    task automatic drive(input logic [1:0] tr, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wdata, input logic rdy, input logic [31:0] prd,
                         input logic rst);
        int s;
        int slot;
        logic [3:0] sel;
        @(posedge Hclk);
        #1;
        cyc++;
        Htrans = tr; Haddr = addr; Hwrite = wr; Hwdata = wdata;
        Hreadyin = rdy; Prdata = prd; Hresetn = rst;
        if (cyc + 4 < MAXC) begin
            if (rst) begin
                clear_from(cyc + 1);
                free_cyc = cyc + 1;
            end else begin
                if (e_wd[cyc])
                    for (int k = cyc + 1; k < MAXC; k++) e_pwdata[k] = wdata;
                if (rdy && tr[1] && addr >= WBASE && addr < WBASE + 4 * WSPAN && cyc >= free_cyc) begin
                    slot = int'((addr - WBASE) / WSPAN);
                    sel  = 4'(1 << slot);
                    s    = wr ? cyc + 2 : cyc + 1;
                    for (int k = cyc + 1; k <= s; k++) e_rdy[k] = 1'b0;
                    if (wr) e_wd[cyc + 1] = 1'b1;
                    e_sel[s] = sel; e_sel[s + 1] = sel;
                    e_en[s + 1] = 1'b1;
                    e_rd[s + 1] = !wr;
                    for (int k = s; k < MAXC; k++) begin
                        e_paddr[k] = addr; e_pwrite[k] = wr;
                    end
                    free_cyc = s + 1;
                    $display("txn cyc=%0d %s addr=%h sel=%b", cyc, wr ? "WR" : "RD", addr, sel);
                end
            end
        end
        @(negedge Hclk);
        #1;
    endtask

    // Every-cycle comparison of all bus outputs against the model.
    always @(negedge Hclk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            chk("pselx",     {28'd0, Pselx},     {28'd0, e_sel[cyc]});
            chk("penable",   {31'd0, Penable},   {31'd0, e_en[cyc]});
            chk("hreadyout", {31'd0, Hreadyout}, {31'd0, e_rdy[cyc]});
            chk("hresp",     {30'd0, Hresp},     32'd0);
            chk("hrdata",    Hrdata,             e_rd[cyc] ? Prdata : 32'd0);
            chk("paddr",     Paddr,              e_paddr[cyc]);
            chk("pwrite",    {31'd0, Pwrite},    {31'd0, e_pwrite[cyc]});
            chk("pwdata",    Pwdata,             e_pwdata[cyc]);
        end
    end

    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    initial begin
        clear_from(0);
        // Reset for two clocks.
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1111_1111, 1'b0);
        chk("rst_pselx", {28'd0, Pselx}, 32'd0);
        chk("rst_hready", {31'd0, Hreadyout}, 32'd1);
        chk("rst_hrdata", Hrdata, 32'd0);

        // Single write.
        drive(T_NSEQ, 32'h8000_0010, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0);
        drive(T_IDLE, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0);
        chk("wr_wwait_hready", {31'd0, Hreadyout}, 32'd0);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        chk("wr_setup_pselx", {28'd0, Pselx}, 32'd1);
        chk("wr_setup_paddr", Paddr, 32'h8000_0010);
        chk("wr_setup_pwdata", Pwdata, 32'hDEAD_BEEF);
        chk("wr_setup_pwrite", {31'd0, Pwrite}, 32'd1);
        chk("wr_setup_hready", {31'd0, Hreadyout}, 32'd0);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        chk("wr_enable_pen", {31'd0, Penable}, 32'd1);
        chk("wr_enable_hready", {31'd0, Hreadyout}, 32'd1);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);

        // Single read.
        drive(T_NSEQ, 32'h8800_0004, 1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
        chk("rd_setup_hrdata", Hrdata, 32'd0);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
        chk("rd_enable_pselx", {28'd0, Pselx}, 32'd4);
        chk("rd_enable_pwrite", {31'd0, Pwrite}, 32'd0);
        chk("rd_enable_hrdata", Hrdata, 32'h1234_5678);
        chk("rd_enable_hready", {31'd0, Hreadyout}, 32'd1);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
        chk("rd_after_hrdata", Hrdata, 32'd0);

        // Ignored transfers.
        drive(T_IDLE, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 32'h2, 1'b0);
        drive(T_BUSY, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 32'h3, 1'b0);
        drive(T_NSEQ, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h4, 1'b0);
        drive(T_NSEQ, 32'h7000_0000, 1'b1, 32'h0, 1'b1, 32'h5, 1'b0);
        drive(T_SEQ,  32'h9000_0000, 1'b0, 32'h0, 1'b1, 32'h6, 1'b0);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h7, 1'b0);
        chk("ign_pselx", {28'd0, Pselx}, 32'd0);
        chk("ign_hready", {31'd0, Hreadyout}, 32'd1);

        // Back-to-back: read then write issued in the read's ENABLE.
        drive(T_NSEQ, 32'h8400_0000, 1'b0, 32'h0, 1'b1, 32'h0A0A_0A0A, 1'b0);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0A0A_0A0A, 1'b0);
        drive(T_NSEQ, 32'h8C00_0008, 1'b1, 32'h0, 1'b1, 32'h0A0A_0A0A, 1'b0);
        chk("b2b_rd_pselx", {28'd0, Pselx}, 32'd2);
        chk("b2b_rd_hrdata", Hrdata, 32'h0A0A_0A0A);
        drive(T_IDLE, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0);
        chk("b2b_wwait_hready", {31'd0, Hreadyout}, 32'd0);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        chk("b2b_wr_pselx", {28'd0, Pselx}, 32'd8);
        chk("b2b_wr_pwdata", Pwdata, 32'hCAFE_F00D);
        chk("b2b_wr_paddr", Paddr, 32'h8C00_0008);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);

        // Back-to-back reads, second one a SEQ transfer.
        drive(T_NSEQ, 32'h8000_0020, 1'b0, 32'h0, 1'b1, 32'h0000_0055, 1'b0);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0066, 1'b0);
        drive(T_SEQ,  32'h8C00_000C, 1'b0, 32'h0, 1'b1, 32'h0000_0077, 1'b0);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0088, 1'b0);
        chk("rr_setup_pselx", {28'd0, Pselx}, 32'd8);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0099, 1'b0);
        chk("rr_enable_hrdata", Hrdata, 32'h0000_0099);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);

        // Reset asserted during the SETUP of a write.
        drive(T_NSEQ, 32'h8400_0004, 1'b1, 32'h0, 1'b1, 32'h0, 1'b0);
        drive(T_IDLE, 32'h0, 1'b0, 32'h55AA_55AA, 1'b1, 32'h0, 1'b0);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        chk("rs_setup_pselx", {28'd0, Pselx}, 32'd2);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        chk("rs_pselx", {28'd0, Pselx}, 32'd0);
        chk("rs_penable", {31'd0, Penable}, 32'd0);
        chk("rs_paddr", Paddr, 32'd0);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        chk("rs_penable2", {31'd0, Penable}, 32'd0);
        drive(T_IDLE, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
